// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: iterative 32-step shift-add multiplier and restoring
// divider with architectural HI/LO registers and busy/done handshake.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic             i_cancel,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d, raw_q, raw_d, hi_q, hi_d, lo_q, lo_d;
  logic               sneg_q, sneg_d, srem_q, srem_d, dz_q, dz_d;
  logic               isdiv_q, isdiv_d, done_q, done_d;

  logic             sgn_op, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn_op   = ~i_op[0];
    neg_a    = sgn_op & i_src_a[WIDTH-1];
    neg_b    = sgn_op & i_src_b[WIDTH-1];
    mag_a    = neg_a ? -i_src_a : i_src_a;
    mag_b    = neg_b ? -i_src_b : i_src_b;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, m_q};
    prod     = sneg_q ? -acc_q : acc_q;
    quo      = sneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = srem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    raw_d   = raw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sneg_d  = sneg_q;
    srem_d  = srem_q;
    dz_d    = dz_q;
    isdiv_d = isdiv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_cancel) begin
          cnt_d   = '0;
          raw_d   = i_src_a;
          dz_d    = (i_src_b == '0);
          sneg_d  = neg_a ^ neg_b;
          srem_d  = neg_a;
          isdiv_d = i_op[1];
          case (i_op)
            3'b000, 3'b001: begin
              state_d = MUL;
              m_d     = mag_a;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
            end
            3'b010, 3'b011: begin
              state_d = DIV;
              m_d     = mag_b;
              acc_d   = {{WIDTH{1'b0}}, mag_a};
            end
            3'b100:  hi_d = i_src_a;
            3'b101:  lo_d = i_src_a;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIXUP;
      end
      DIV: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (!isdiv_q)  {hi_d, lo_d} = prod;
        else if (dz_q) begin
          hi_d = raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = IDLE;
    endcase
    // Squash beats everything, including the FIXUP write-back.
    if (i_cancel && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      raw_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sneg_q  <= 1'b0;
      srem_q  <= 1'b0;
      dz_q    <= 1'b0;
      isdiv_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      raw_q   <= raw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sneg_q  <= sneg_d;
      srem_q  <= srem_d;
      dz_q    <= dz_d;
      isdiv_q <= isdiv_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: reference results queued at issue,
// popped and compared when o_done pulses.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, i_start, i_cancel;
  logic [2:0]  i_op;
  logic [31:0] i_src_a, i_src_b;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int          n_tests = 0, n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op), .i_cancel(i_cancel),
    .i_src_a(i_src_a), .i_src_b(i_src_b), .o_busy(o_busy), .o_done(o_done),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // dup_at: extra i_start presented at edge E<dup_at>; cancel_at: i_cancel at edge E<cancel_at>
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int dup_at, input int cancel_at);
    int busy_cnt, k;
    logic seen;
    busy_cnt = 0;
    seen = 1'b0;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
    if (cancel_at == 0) exp_q.push_back(model(op, a, b));
    @(negedge clk);
    i_start = 1'b0;
    for (k = 1; k < 60; k++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) busy_cnt++;
      i_start  = (k == dup_at);
      if (k == dup_at) begin
        i_op = 3'b011; i_src_a = 32'h1234_5678; i_src_b = 32'h3;
      end
      i_cancel = (k == cancel_at);
      if (cancel_at != 0 && k > cancel_at + 2) break;
      @(negedge clk);
    end
    i_start = 1'b0; i_cancel = 1'b0;
    if (cancel_at == 0) begin
      chk("done_seen", {63'b0, seen}, 64'd1);
      chk("busy_cycles", busy_cnt, 64'd33);
      if (exp_q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hilo", {o_hi, o_lo}, e);
        {m_hi, m_lo} = e;
      end
      @(negedge clk);
      chk("done_pulse", {63'b0, o_done}, 64'd0);
    end else begin
      chk("cancel_no_done", {63'b0, seen}, 64'd0);
      chk("cancel_busy_cycles", busy_cnt, cancel_at);
      chk("cancel_idle", {63'b0, o_busy}, 64'd0);
      chk("cancel_hilo", {o_hi, o_lo}, {m_hi, m_lo});
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a, input logic cancel);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_src_a = a; i_cancel = cancel;
    if (!cancel) begin
      if (op == 3'b100) m_hi = a;
      if (op == 3'b101) m_lo = a;
    end
    @(negedge clk);
    i_start = 1'b0; i_cancel = 1'b0;
    chk("mt_hilo", {o_hi, o_lo}, {m_hi, m_lo});
    chk("mt_nobusy", {62'b0, o_busy, o_done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_cancel = 1'b0; i_op = 3'b0;
    i_src_a = '0; i_src_b = '0; m_hi = '0; m_lo = '0;
    #12;
    chk("reset_state", {o_hi, o_lo}, 64'd0);
    chk("reset_ctrl", {62'b0, o_busy, o_done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'b001, 32'd7, 32'd6, 0, 0);
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 0, 0);
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd10, 0, 0);
    run_op(3'b011, 32'd123, 32'd0, 0, 0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'b010, 32'hFFFF_FF00, 32'd0, 0, 0);
    for (int i = 0; i < 8; i++)
      run_op(3'($urandom_range(0, 3)), $urandom, (i % 2 == 0) ? $urandom : $urandom_range(1, 300), 0, 0);

    mt(3'b100, 32'h0000_ABCD, 1'b0);
    mt(3'b101, 32'h0000_1111, 1'b0);
    mt(3'b100, 32'hDEAD_BEEF, 1'b1);
    mt(3'b110, 32'hDEAD_BEEF, 1'b0);
    run_op(3'b000, 32'd9, 32'd9, 5, 0);
    run_op(3'b000, 32'd9, 32'd9, 0, 10);
    run_op(3'b011, 32'd100, 32'd7, 0, 33);
    mt(3'b100, 32'h0000_ABCD, 1'b0);

    @(negedge clk);
    i_start = 1'b1; i_op = 3'b010; i_src_a = 32'd1000; i_src_b = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_hilo", {o_hi, o_lo}, 64'd0);
    chk("midreset_ctrl", {62'b0, o_busy, o_done}, 64'd0);
    @(negedge clk);
    reset = 1'b0; m_hi = '0; m_lo = '0;
    mt(3'b101, 32'd5, 1'b0);
    repeat (40) @(negedge clk);
    chk("no_late_done", {62'b0, o_busy, o_done}, 64'd0);
    chk("queue_drained", exp_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
